l2_sqrt_stage: RTL
==================

Name: l2_sqrt_stage

Overview:
- Downstream stage of the sum-of-squares accumulator (part2). Consumes its 20-bit result f, its valid_out pulse and its overflow flag.
- Produces the integer square root, i.e. the final L2 norm.
- Iterative restoring digit-by-digit square root, one result bit per clock, behind a small input FIFO.
- The FIFO exists because the upstream block has no backpressure.

Parameters:
- IN_W, 20, radicand width. Must be even. Output width OUT_W = IN_W/2 is a derived localparam.
- FIFO_DEPTH, 4, input FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- f_in  input  IN_W  radicand (upstream f).
- ovf_in  input  1  upstream overflow flag, sampled with f_in.
- valid_in  input  1  f_in/ovf_in valid this cycle; single-cycle pulses, possibly back-to-back.
- root  output  OUT_W  square-root result, held until the next result.
- ovf_out  output  1  overflow tag for root, held with root.
- valid_out  output  1  one-cycle pulse when root/ovf_out update.
- busy  output  1  engine in CALC or FIFO non-empty.
- drop  output  1  one-cycle pulse: valid_in arrived while FIFO full; sample discarded.

Behaviour:
- Reset (async assert, sync release): root=0, ovf_out=0, valid_out=0, drop=0, busy=0, FIFO emptied, state=IDLE, iteration count=0. Any in-flight computation is discarded; no valid_out is produced for it.
- FIFO:
  - Stores {ovf_in, f_in} on each valid_in if not full.
  - Push when full: drop=1 next cycle, entry discarded, FIFO contents unchanged.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and drop=0.
  - Output order equals input order.
- FSM, states IDLE and CALC:
  - IDLE: if FIFO non-empty, pop. Load rad=f_in, rem=0, acc=0, cnt=0, tag=ovf_in. Go to CALC.
  - CALC, each edge:
    - rem = (rem<<2) | top two bits of rad, then rad <<= 2.
    - trial = (acc<<2)|1.
    - If rem ≥ trial: rem -= trial, acc = (acc<<1)|1. Else acc <<= 1.
    - cnt++.
  - rem is OUT_W+2 bits wide; no truncation is permitted.
  - On the edge completing iteration OUT_W (the 10th by default), register root=acc and ovf_out=tag, set valid_out=1 for one cycle, return to IDLE.
- Latency with FIFO empty and engine IDLE: the sample is taken at edge E0, pop at E1, iterations at E1+1 … E1+OUT_W. valid_out is high in the cycle after edge E0+OUT_W+1, i.e. 11 edges after E0 by default.
- Throughput: one result per OUT_W+1 cycles.
- Overflow tag: if the popped entry has ovf_in=1, root is forced to all-ones (1023) and ovf_out=1. The computation still takes the full latency so output spacing is constant.
- root is the floor of sqrt(f_in), so root² ≤ f_in < (root+1)².
- busy deasserts only when state=IDLE and the FIFO is empty.

Optional Feature:
- Macro L2_SQRT_ROUND_EN.
- Defined: after the final iteration, if rem > acc, increment the result (round to nearest; a .5 tie cannot occur for integer input). If the increment would exceed 2^OUT_W−1, saturate at all-ones. Latency is unchanged.
- Undefined: truncating (floor) result exactly as in Behaviour.

Test Plan:
- Reset then f_in=0 valid_in pulse → valid_out pulse exactly 11 edges later, root=0, ovf_out=0, busy high in between.
- Separate pulses f_in=15, 1000000, 1048575 → root=3, 1000, 1023. Each valid_out is a single cycle and root is held afterwards.
- f_in=5 with ovf_in=1 → root=1023, ovf_out=1, same 11-cycle latency. The next clean f_in=16 → root=4, ovf_out=0.
- 6 back-to-back valid_in (f_in=1,4,9,16,25,36) on empty FIFO, FIFO_DEPTH=4:
  - Sample 1 is popped at E1; samples 2–5 fill the FIFO.
  - Sample 6 → drop pulse, no sixth result.
  - root=1,2,3,4,5 in order, spaced 11 cycles.
- reset asserted mid-CALC for f_in=100 → outputs zero immediately, no valid_out for that sample. After release, f_in=144 → root=12 after 11 edges.
- With L2_SQRT_ROUND_EN: f_in=15 → 4; f_in=12 → 3; f_in=1048575 → 1023 (saturated).

Source files
------------

// File: rtl/l2_sqrt_stage.sv
// Integer square-root stage for the L2-norm pipeline: a small input FIFO feeding a
// restoring digit-by-digit engine (one root bit per clock). Optional rounding: L2_SQRT_ROUND_EN.
module l2_sqrt_stage #(
  parameter int IN_W       = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_W-1:0]     f_in,
  input  logic                ovf_in,
  input  logic                valid_in,
  output logic [IN_W/2-1:0]   root,
  output logic                ovf_out,
  output logic                valid_out,
  output logic                busy,
  output logic                drop
);

  localparam int OUT_W = IN_W / 2;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW    = IN_W + 1;
  localparam int RW    = OUT_W + 2;
  localparam int CW    = $clog2(OUT_W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  // Handshake: valid_in is a one-cycle strobe with no ready; the FIFO absorbs
  // bursts and a strobe arriving while full (and not being freed) is reported via drop.
  // valid_out is a one-cycle strobe; root/ovf_out hold until the next strobe.

  state_t               state_q, state_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 fifo_empty, fifo_full, push, pop;
  logic [EW-1:0]        head;

  logic [IN_W-1:0]      rad_q, rad_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tag_q, tag_d;
  logic [OUT_W-1:0]     root_q, root_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 drop_q, drop_d;

  logic [RW+1:0]        rem_sh, trial;
  logic                 rem_ge;
  logic [RW-1:0]        rem_nx;
  logic [OUT_W-1:0]     acc_nx;
  logic                 last_iter;
  logic [OUT_W-1:0]     res;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO is still accepted.
  assign push       = valid_in && (!fifo_full || pop);
  assign drop_d     = valid_in && fifo_full && !pop;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ovf_in, f_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // One restoring step; the widened intermediates keep the shifted remainder and
  // the trial divisor exact before the difference is stored back.
  always_comb begin
    rem_sh    = {rem_q, rad_q[IN_W-1 -: 2]};
    trial     = {2'b00, acc_q, 2'b01};
    rem_ge    = (rem_sh >= trial);
    rem_nx    = rem_ge ? RW'(rem_sh - trial) : RW'(rem_sh);
    acc_nx    = {acc_q[OUT_W-2:0], rem_ge};
    last_iter = (cnt_q == CW'(OUT_W - 1));
  end

`ifdef L2_SQRT_ROUND_EN
  // rem > acc means f exceeds acc^2 + acc, i.e. sqrt(f) >= acc + 0.5.
  always_comb begin
    res = acc_nx;
    if ((rem_nx > RW'(acc_nx)) && (acc_nx != '1)) begin
      res = acc_nx + OUT_W'(1);
    end
  end
`else
  always_comb begin
    res = acc_nx;
  end
`endif

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    root_d      = root_q;
    ovf_out_d   = ovf_out_q;
    valid_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rad_d   = head[IN_W-1:0];
          rem_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          tag_d   = head[IN_W];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rad_d = rad_q << 2;
        rem_d = rem_nx;
        acc_d = acc_nx;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          root_d      = tag_q ? '1 : res;
          ovf_out_d   = tag_q;
          valid_out_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tag_q       <= 1'b0;
      root_q      <= '0;
      ovf_out_q   <= 1'b0;
      valid_out_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      root_q      <= root_d;
      ovf_out_q   <= ovf_out_d;
      valid_out_q <= valid_out_d;
      drop_q      <= drop_d;
    end
  end

  assign root      = root_q;
  assign ovf_out   = ovf_out_q;
  assign valid_out = valid_out_q;
  assign drop      = drop_q;
  assign busy      = (state_q == S_CALC) || !fifo_empty;

endmodule
